// File: rtl/swish_backward.sv
// Streaming backward-pass unit for Swish: dx = dy * s * (1 + x*(1 - s)), s = PWL sigmoid(x).
// Q16.16 fixed point, 4-stage pipeline with a single global enable for valid/ready flow control.
module swish_backward #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] dy_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dx_out,
  output logic              sat_out
);

  localparam logic [16:0]        ONE   = 17'd65536;
  localparam logic signed [49:0] R_MAX = 50'sd2147483647;
  localparam logic signed [49:0] R_MIN = -50'sd2147483648;

  // Stage valid bits and the shared advance enable.
  logic r_v1, r_v2, r_v3, r_v4;
  logic w_en;

  assign w_en      = !r_v4 || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v4;

  // ---------------- S1: piecewise-linear sigmoid ----------------
  logic [31:0] w_abs;
  logic [16:0] w_p;
  logic [16:0] w_s;

  // NOTE: every variable assigned in always_comb gets a default on entry so no path leaves it unassigned (no latch).
  always_comb begin
    w_abs = x_in;
    w_p   = ONE;
    if (x_in[31]) w_abs = (x_in == 32'h8000_0000) ? 32'h7FFF_FFFF : (32'd0 - x_in);
    if (w_abs >= 32'd327680)      w_p = ONE;
    else if (w_abs >= 32'd155648) w_p = 17'(w_abs >> 5) + 17'd55296;
    else if (w_abs >= 32'd65536)  w_p = 17'(w_abs >> 3) + 17'd40960;
    else                          w_p = 17'(w_abs >> 2) + 17'd32768;
    w_s = x_in[31] ? (ONE - w_p) : w_p;
  end

  logic signed [31:0] r_s1_x;
  logic signed [31:0] r_s1_dy;
  logic        [16:0] r_s1_s;

  // ---------------- S2: u = (x * (1 - s)) >>> 16 ----------------
  logic        [16:0] w_t;
  logic signed [49:0] w_xt;
  logic signed [33:0] w_u;

  assign w_t  = ONE - r_s1_s;
  assign w_xt = 50'(r_s1_x) * 50'($signed({1'b0, w_t}));
  assign w_u  = 34'(w_xt >>> FRAC_W);

  logic signed [33:0] r_s2_u;
  logic        [16:0] r_s2_s;
  logic signed [31:0] r_s2_dy;

  // ---------------- S3: g = (s * (1 + u)) >>> 16 ----------------
  logic signed [33:0] w_v;
  logic signed [51:0] w_sv;
  logic signed [33:0] w_g;

  assign w_v  = 34'sd65536 + r_s2_u;
  assign w_sv = 52'($signed({1'b0, r_s2_s})) * 52'(w_v);
  assign w_g  = 34'(w_sv >>> FRAC_W);

  logic signed [33:0] r_s3_g;
  logic signed [31:0] r_s3_dy;

  // ---------------- S4: r = (dy * g) >>> 16, saturate to 32 bits ----------------
  logic signed [65:0] w_r_full;
  logic signed [49:0] w_r;
  logic        [31:0] w_dx;
  logic               w_sat;

  assign w_r_full = 66'(r_s3_dy) * 66'(r_s3_g);
  assign w_r      = 50'(w_r_full >>> FRAC_W);

  always_comb begin
    w_dx  = 32'(w_r);
    w_sat = 1'b0;
    if (w_r > R_MAX) begin
      w_dx  = 32'h7FFF_FFFF;
      w_sat = 1'b1;
    end else if (w_r < R_MIN) begin
      w_dx  = 32'h8000_0000;
      w_sat = 1'b1;
    end
  end

  logic [31:0] r_dx;
  logic        r_sat;

  assign dx_out  = r_dx;
  assign sat_out = r_sat;

  // NOTE: sequential state uses non-blocking assignment so all stages shift on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_v4  <= 1'b0;
      r_dx  <= '0;
      r_sat <= 1'b0;
    end else if (w_en) begin
      r_v1  <= in_valid;
      r_v2  <= r_v1;
      r_v3  <= r_v2;
      r_v4  <= r_v3;
      r_dx  <= w_dx;
      r_sat <= w_sat;
    end
  end

  // NOTE: datapath registers carry no reset; their contents are ignored whenever the matching valid bit is 0.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_s1_x  <= x_in;
      r_s1_dy <= dy_in;
      r_s1_s  <= w_s;
      r_s2_u  <= w_u;
      r_s2_s  <= r_s1_s;
      r_s2_dy <= r_s1_dy;
      r_s3_g  <= w_g;
      r_s3_dy <= r_s2_dy;
    end
  end

endmodule

// File: tb/tb_swish_backward.sv
// Directed and randomized checks for swish_backward: latency, arithmetic corners,
// saturation, backpressure/hold, reset flush and a bit-exact reference model.
module tb_swish_backward;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic [31:0] dy_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dx_out;
  logic        sat_out;

  int checks   = 0;
  int failures = 0;

  swish_backward #(.DATA_W(32), .FRAC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .dy_in     (dy_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dx_out    (dx_out),
    .sat_out   (sat_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model from the arithmetic definition; returns {sat, dx}.
  function automatic logic [32:0] ref_dx(input logic [31:0] x, input logic [31:0] dy);
    longint xl, dyl, a, p, s, t, u, v, g, r;
    logic [63:0] rb;
    xl  = longint'($signed(x));
    dyl = longint'($signed(dy));
    a   = (xl < 0) ? -xl : xl;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    if (a >= 327680)      p = 65536;
    else if (a >= 155648) p = (a >>> 5) + 55296;
    else if (a >= 65536)  p = (a >>> 3) + 40960;
    else                  p = (a >>> 2) + 32768;
    s = (xl < 0) ? 65536 - p : p;
    t = 65536 - s;
    u = (xl * t) >>> 16;
    v = 65536 + u;
    g = (s * v) >>> 16;
    r = (dyl * g) >>> 16;
    rb = r;
    if (r > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (r < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, rb[31:0]};
  endfunction

  function automatic logic [31:0] gen_x();
    logic [31:0] corners [10];
    corners = '{32'h0000_0000, 32'h0001_0000, 32'h0000_FFFF, 32'h0002_6000, 32'h0002_5FFF,
                32'h0005_0000, 32'h0004_FFFF, 32'hFFFB_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 786432)) - 32'd393216;
      2:       return corners[$urandom_range(0, 9)];
      default: return 32'($urandom_range(0, 2097152)) - 32'd1048576;
    endcase
  endfunction

  function automatic logic [31:0] gen_dy();
    if ($urandom_range(0, 1) == 0) return $urandom;
    return 32'($urandom_range(0, 1048576)) - 32'd524288;
  endfunction

  // Drives one element with out_ready high and waits for its result; returns what the DUT showed.
  task automatic push_and_wait(input logic [31:0] x, input logic [31:0] dy,
                               output logic got, output logic [31:0] dx, output logic sat,
                               output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    x_in      = x;
    dy_in     = dy;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = out_valid;
    dx  = dx_out;
    sat = sat_out;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    dy_in     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (dx_out !== 32'h0) begin failures++; $display("FAIL reset_dx got=%h want=00000000", dx_out); end
    checks++;
    if (sat_out !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b want=0", sat_out); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_zero_latency();
    int   lat;
    logic rdy_ok;
    @(negedge clk);
    in_valid  = 1'b1;
    x_in      = 32'h0000_0000;
    dy_in     = 32'h0001_0000;
    out_ready = 1'b1;
    #1;
    rdy_ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    rdy_ok &= in_ready;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      rdy_ok &= in_ready;
    end
    checks++;
    if (lat != 4) begin failures++; $display("FAIL zero_latency got=%0d want=4", lat); end
    checks++;
    if (dx_out !== 32'h0000_8000) begin failures++; $display("FAIL zero_dx got=%h want=00008000", dx_out); end
    checks++;
    if (sat_out !== 1'b0) begin failures++; $display("FAIL zero_sat got=%b want=0", sat_out); end
    checks++;
    if (rdy_ok !== 1'b1) begin failures++; $display("FAIL zero_in_ready got=%b want=1", rdy_ok); end
  endtask

  task automatic test_stream();
    logic [31:0] xs  [3];
    logic [31:0] exp [3];
    xs  = '{32'h0001_0000, 32'hFFFF_0000, 32'h0008_0000};
    exp = '{32'h0000_F000, 32'h0000_1000, 32'h0001_0000};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x_in     = xs[i];
      dy_in    = 32'h0001_0000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, dx_out} !== {1'b1, exp[i]}) begin
        failures++;
        $display("FAIL stream_%0d got valid=%b dx=%h want valid=1 dx=%h", i, out_valid, dx_out, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_tail got=%b want=0", out_valid); end
  endtask

  task automatic test_saturation();
    logic got, sat;
    logic [31:0] dx;
    int lat;
    push_and_wait(32'h0002_0000, 32'h7FFF_0000, got, dx, sat, lat);
    checks++;
    if ({got, sat, dx} !== {1'b1, 1'b1, 32'h7FFF_FFFF}) begin
      failures++; $display("FAIL sat_pos got v=%b s=%b dx=%h want v=1 s=1 dx=7fffffff", got, sat, dx);
    end
    push_and_wait(32'h0002_0000, 32'h8001_0000, got, dx, sat, lat);
    checks++;
    if ({got, sat, dx} !== {1'b1, 1'b1, 32'h8000_0000}) begin
      failures++; $display("FAIL sat_neg got v=%b s=%b dx=%h want v=1 s=1 dx=80000000", got, sat, dx);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] xs  [7];
    logic [31:0] dys [7];
    logic [31:0] exp [7];
    logic got, sat;
    logic [31:0] dx;
    int lat;
    xs  = '{32'h8000_0000, 32'h0005_0000, 32'h0004_FFFF, 32'h0002_6000,
            32'hFFFF_8000, 32'hFFFF_FFFF, 32'h0000_0000};
    dys = '{32'h1234_5678, 32'h1234_5678, 32'h0001_0000, 32'h0001_0000,
            32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF};
    exp = '{32'h0000_0000, 32'h1234_5678, 32'h0001_0002, 32'h0001_18C8,
            32'h0000_4200, 32'h0000_7FFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      push_and_wait(xs[i], dys[i], got, dx, sat, lat);
      checks++;
      if ({got, sat, dx} !== {1'b1, 1'b0, exp[i]}) begin
        failures++;
        $display("FAIL boundary_%0d x=%h got v=%b s=%b dx=%h want v=1 s=0 dx=%h", i, xs[i], got, sat, dx, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] xs  [4];
    logic [31:0] exp [4];
    xs  = '{32'h0001_0000, 32'hFFFF_0000, 32'h0008_0000, 32'h0000_0000};
    exp = '{32'h0000_F000, 32'h0000_1000, 32'h0001_0000, 32'h0000_8000};
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      x_in     = xs[i];
      dy_in    = 32'h0001_0000;
      @(negedge clk);
    end
    // A pending element offered during the stall must not enter the pipe.
    x_in  = 32'h0003_0000;
    dy_in = 32'h0001_0000;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, dx_out} !== {1'b0, 1'b1, exp[0]}) begin
        failures++;
        $display("FAIL stall_%0d got rdy=%b v=%b dx=%h want rdy=0 v=1 dx=%h", c, in_ready, out_valid, dx_out, exp[0]);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if ({out_valid, dx_out} !== {1'b1, exp[i]}) begin
        failures++;
        $display("FAIL drain_%0d got v=%b dx=%h want v=1 dx=%h", i, out_valid, dx_out, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_extra got=%b want=0", out_valid); end
  endtask

  task automatic test_random();
    logic [32:0] q [$];
    logic [32:0] exp;
    logic [32:0] hold_val;
    logic        hold_armed;
    logic        pend;
    int sent, recvd, cyc;
    sent = 0; recvd = 0; cyc = 0; pend = 1'b0; hold_armed = 1'b0; hold_val = '0;
    while ((sent < 1000 || recvd < sent) && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
        x_in  = gen_x();
        dy_in = gen_dy();
        pend  = 1'b1;
      end
      in_valid  = pend;
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (hold_armed) begin
        checks++;
        if ({out_valid, sat_out, dx_out} !== {1'b1, hold_val}) begin
          failures++;
          $display("FAIL rand_hold got v=%b sdx=%h want v=1 sdx=%h", out_valid, {sat_out, dx_out}, hold_val);
        end
      end
      hold_armed = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL rand_spurious got dx=%h want no output", dx_out);
          end else begin
            exp = q.pop_front();
            if ({sat_out, dx_out} !== exp) begin
              failures++;
              $display("FAIL rand_%0d got s=%b dx=%h want s=%b dx=%h", recvd, sat_out, dx_out, exp[32], exp[31:0]);
            end
          end
          recvd++;
        end else begin
          hold_armed = 1'b1;
          hold_val   = {sat_out, dx_out};
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_dx(x_in, dy_in));
        sent++;
        pend = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (recvd != 1000 || q.size() != 0) begin
      failures++;
      $display("FAIL rand_count got recvd=%0d left=%0d want recvd=1000 left=0", recvd, q.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] xs [3];
    logic seen, got, sat;
    logic [31:0] dx;
    int lat;
    xs = '{32'h0001_0000, 32'hFFFF_0000, 32'h0008_0000};
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x_in     = xs[i];
      dy_in    = 32'h0001_0000;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      seen |= out_valid;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL midrst_flushed got=%b want=0", seen); end
    push_and_wait(32'h0001_0000, 32'h0001_0000, got, dx, sat, lat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL midrst_latency got=%0d want=4", lat); end
    checks++;
    if ({got, sat, dx} !== {1'b1, 1'b0, 32'h0000_F000}) begin
      failures++; $display("FAIL midrst_dx got v=%b s=%b dx=%h want v=1 s=0 dx=0000f000", got, sat, dx);
    end
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_stream();
    test_saturation();
    test_boundaries();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/swish_backward.md
Name: swish_backward

Overview:
- Streaming gradient (backward-pass) unit for the Swish activation y = x·sigmoid(x).
- Per element, takes forward input x and upstream gradient dy and produces dx = dy · s · (1 + x·(1 − s)), where s = sigmoid(x).
- Sits in the training datapath, opposite the forward Swish operator.
- Uses the same 32-bit element format as the forward operator. Fixed-point 4-stage pipeline with valid/ready flow control.

Parameters:
- DATA_W, 32, element width; signed two's-complement fixed point.
- FRAC_W, 16, fractional bits (Q16.16). Scaled constants below assume FRAC_W=16.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  x_in/dy_in valid
- in_ready  output  1  unit accepts an element this cycle
- x_in  input  DATA_W  forward activation input x, Q16.16
- dy_in  input  DATA_W  upstream gradient dy, Q16.16
- out_valid  output  1  dx_out valid
- out_ready  input  1  downstream accepts
- dx_out  output  DATA_W  gradient dx, Q16.16
- sat_out  output  1  dx_out was saturated; qualified by out_valid

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: all stage valid bits = 0; out_valid=0, dx_out=0, sat_out=0. On reset mid-operation, in-flight elements are discarded and not emitted.
- Flow control:
  - en = !out_valid | out_ready; in_ready = en (combinational from out_ready, no other logic).
  - When en=1, all stages advance together. Stage-1 valid loads in_valid & in_ready.
  - When en=0, every stage register holds.
  - Bubbles propagate as valid=0, with no compaction.
- Latency: 4 cycles from accept to out_valid when unstalled. Throughput: 1 element/cycle.
- Output hold: dx_out/sat_out stay stable while out_valid=1 and out_ready=0.
- S1, sigmoid, piecewise-linear:
  - a = |x|; abs(−2^31) saturates to 0x7FFFFFFF.
  - a ≥ 327680 (5.0): p = 65536.
  - a ≥ 155648 (2.375): p = (a>>5) + 55296.
  - a ≥ 65536 (1.0): p = (a>>3) + 40960.
  - else: p = (a>>2) + 32768.
  - s = p if x ≥ 0, else 65536 − p. s always lies in [0, 65536].
  - x and dy are carried forward.
- S2: t = 65536 − s. u = (x·t) >>> 16, using a 64-bit signed product and arithmetic shift (floor). s carried forward.
- S3: v = 65536 + u. g = (s·v) >>> 16, 64-bit signed. g is the local derivative.
- S4:
  - r = (dy·g) >>> 16, 64-bit signed.
  - If r > 0x7FFFFFFF, dx = 0x7FFFFFFF and sat=1.
  - If r < −2^31, dx = 0x80000000 and sat=1.
  - Else dx = r[31:0] and sat=0.
- Intermediate widths: u, v, g are held in ≥34-bit signed registers. Only the final output saturates.
- Segment boundaries: a equal to a threshold takes the higher segment. x=0 gives s=32768 exactly.
- Simultaneous events:
  - Output accept and input accept in the same cycle are legal. With out_ready held high, full throughput is sustained.
  - in_valid while in_ready=0: the element is not captured, and the source must hold it.

Test Plan:
- Reset, then x=0x00000000, dy=0x00010000 with out_ready=1 → exactly 4 cycles later dx_out=0x00008000, sat_out=0; in_ready=1 throughout.
- Stream x={0x00010000, 0xFFFF0000, 0x00080000} (1.0, −1.0, 8.0), dy=0x00010000 each, back-to-back → dx_out={0x0000F000, 0x00001000, 0x00010000} on consecutive cycles, order preserved.
- x=0x00020000 (2.0), dy=0x7FFF0000 → dx_out=0x7FFFFFFF, sat_out=1. Same x with dy=0x80010000 → dx_out=0x80000000, sat_out=1.
- x=0x80000000, dy=0x12345678 → dx_out=0 (s=0). x=0x00050000 exactly → s=65536, dx_out=dy.
- Backpressure:
  - Fill the pipe with 4 elements, drop out_ready for 5 cycles → in_ready=0, and dx_out/out_valid are stable.
  - Raise out_ready → all 4 results emerge in order with none lost or duplicated.
  - Random out_ready toggling over 1000 elements, checked against a bit-exact reference model.
- Assert rst for one cycle with 3 elements in flight → out_valid=0 next cycle, none of the 3 is ever emitted, and a fresh element afterwards has 4-cycle latency.
